// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the core's data-memory ready/valid interface. It
// replaces an external data RAM in simulation and FPGA builds and sits below
// the CLINT address split.
//
// The read and write channels are independent. Each channel counts its
// programmable wait states, then accepts the request (valid = ready & cnt==WAIT).
// Requests outside the BASE_ADDR region are still accepted. They leave the RAM
// unchanged and set the sticky err flag.
//
// Optional feature:
//   `define DMEM_RAW_FWD_EN  A read and an in-range write that handshake in the
//                            same cycle on the same word return merged data.
//                            Strobed lanes take dmem_wdata; the other lanes take
//                            the old RAM data. Without the macro the read returns
//                            the old word (read-before-write), and no
//                            forwarding mux is built.
//
// Parameters:
//   AW        word-address width; capacity 4*2^AW bytes
//   BASE_ADDR region base; addr[31:AW+2] must match for a request to be in range
//   RD_WAIT   wait states before dmem_rvalid asserts on a held request
//   WR_WAIT   wait states before dmem_wvalid asserts on a held request
//
// Ports:
//   clk          clock
//   resetb       synchronous active-low reset
//   dmem_rready  read request            dmem_rvalid  read accept
//   dmem_raddr   read byte address       dmem_rresp   1 = OK, 0 = out of range
//   dmem_rdata   read data (registered; valid the cycle after the handshake)
//   dmem_wready  write request           dmem_wvalid  write accept
//   dmem_waddr   write byte address      dmem_wdata   write data
//   dmem_wstrb   byte enables (bit i covers wdata[8i+7:8i])
//   err          sticky out-of-range flag; only reset clears it
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned AW        = 14,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int unsigned RD_WAIT   = 0,
    parameter int unsigned WR_WAIT   = 0
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        dmem_rready,
    output logic        dmem_rvalid,
    input  logic [31:0] dmem_raddr,
    output logic        dmem_rresp,
    output logic [31:0] dmem_rdata,
    input  logic        dmem_wready,
    output logic        dmem_wvalid,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        err
);

    localparam int unsigned RCW   = (RD_WAIT == 0) ? 1 : $clog2(RD_WAIT + 1);
    localparam int unsigned WCW   = (WR_WAIT == 0) ? 1 : $clog2(WR_WAIT + 1);
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [RCW-1:0] RD_LAST = RCW'(RD_WAIT);
    localparam logic [WCW-1:0] WR_LAST = WCW'(WR_WAIT);

    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [31:0]    rdata_q;
    logic           rresp_q;
    logic           err_q, err_d;

    logic           rd_hs, wr_hs;
    logic           rd_in_range, wr_in_range;
    logic [AW-1:0]  rd_idx, wr_idx;

    logic [31:0]    mem [DEPTH];

    // Byte offset bits are intentionally unused. The strobes select the lanes.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^{dmem_raddr[1:0], dmem_waddr[1:0]};

    assign rd_idx      = dmem_raddr[AW+1:2];
    assign wr_idx      = dmem_waddr[AW+1:2];
    assign rd_in_range = (dmem_raddr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign wr_in_range = (dmem_waddr[31:AW+2] == BASE_ADDR[31:AW+2]);

    // Valid is gated by resetb. This keeps both accepts low during reset and
    // discards any handshake that coincides with a reset cycle.
    assign dmem_rvalid = resetb & dmem_rready & (rcnt_q == RD_LAST);
    assign dmem_wvalid = resetb & dmem_wready & (wcnt_q == WR_LAST);
    assign rd_hs       = dmem_rready & dmem_rvalid;
    assign wr_hs       = dmem_wready & dmem_wvalid;

    // Counters advance while a request is held short of WAIT. They drop to 0
    // on a handshake, and also when the request is abandoned.
    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rcnt_d = '0;
        wcnt_d = '0;
        if (dmem_rready && (rcnt_q != RD_LAST)) rcnt_d = rcnt_q + RCW'(1);
        if (dmem_wready && (wcnt_q != WR_LAST)) wcnt_d = wcnt_q + WCW'(1);
    end

    assign err_d = err_q | (rd_hs & ~rd_in_range) | (wr_hs & ~wr_in_range);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // block samples pre-edge values (this is also what gives read-before-write).
    always_ff @(posedge clk) begin
        if (!resetb) begin
            rcnt_q  <= '0;
            wcnt_q  <= '0;
            rdata_q <= '0;
            rresp_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
            if (rd_hs) begin
                if (rd_in_range) begin
                    rresp_q <= 1'b1;
                    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_RAW_FWD_EN
                        if (wr_hs && wr_in_range && (wr_idx == rd_idx) && dmem_wstrb[i])
                            rdata_q[8*i +: 8] <= dmem_wdata[8*i +: 8];
                        else
                            rdata_q[8*i +: 8] <= mem[rd_idx][8*i +: 8];
`else
                        rdata_q[8*i +: 8] <= mem[rd_idx][8*i +: 8];
`endif
                    end
                end else begin
                    rresp_q <= 1'b0;
                    rdata_q <= '0;
                end
            end
        end
    end

    // NOTE: the RAM array is deliberately not reset. Contents survive resetb,
    // and the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_hs && wr_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wstrb[i]) mem[wr_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
            end
        end
    end

    assign dmem_rdata = rdata_q;
    assign dmem_rresp = rresp_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responder instances with different wait-state settings:
//   0: RD_WAIT=0, WR_WAIT=0
//   1: RD_WAIT=2, WR_WAIT=3
//   2: RD_WAIT=3, WR_WAIT=1
//
// The driver raises ready and checks that valid appears on cycle WAIT+1. At each
// read handshake it pushes the expected read response into a scoreboard queue.
// That expectation comes from a word-addressed associative-array model of the
// RAM plus the range rule. A separate monitor detects handshakes and, one cycle
// later, pops the queue and compares rdata, rresp and err.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int NI = 3;

    function automatic int unsigned rdw(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int unsigned wrw(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    logic        clk;
    logic        resetb;
    logic        rready [NI];
    logic        rvalid [NI];
    logic [31:0] raddr  [NI];
    logic        rresp  [NI];
    logic [31:0] rdata  [NI];
    logic        wready [NI];
    logic        wvalid [NI];
    logic [31:0] waddr  [NI];
    logic [31:0] wdata  [NI];
    logic [3:0]  wstrb  [NI];
    logic        err    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .RD_WAIT (rdw(g)),
            .WR_WAIT (wrw(g))
        ) u_dut (
            .clk         (clk),
            .resetb      (resetb),
            .dmem_rready (rready[g]),
            .dmem_rvalid (rvalid[g]),
            .dmem_raddr  (raddr[g]),
            .dmem_rresp  (rresp[g]),
            .dmem_rdata  (rdata[g]),
            .dmem_wready (wready[g]),
            .dmem_wvalid (wvalid[g]),
            .dmem_waddr  (waddr[g]),
            .dmem_wdata  (wdata[g]),
            .dmem_wstrb  (wstrb[g]),
            .err         (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ model
    typedef struct {
        int          k;
        logic [31:0] data;
        logic        resp;
    } rd_exp_t;

    rd_exp_t     sbq [$];
    logic [31:0] mdl [int unsigned];
    logic        err_exp [NI];
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic bit in_rng(input logic [31:0] a);
        return a[31:16] == 16'h2000;   // 64 KB region at 0x2000_0000
    endfunction

    function automatic int unsigned key(input int k, input logic [31:0] a);
        return k * 65536 + int'({18'b0, a[15:2]});
    endfunction

    function automatic logic [31:0] mrd(input int k, input logic [31:0] a);
        if (mdl.exists(key(k, a))) return mdl[key(k, a)];
        return 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ----------------------------------------------------------------- driver
    // Called at a falling edge. Holds each requested channel until it handshakes.
    task automatic xfer(input int k, input bit dr, input logic [31:0] ra,
                        input bit dw, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws);
        bit      rp, wp, rv, wv;
        int      c;
        rd_exp_t e;
        rp = dr; wp = dw; c = 0;
        rready[k] = dr; raddr[k] = ra;
        wready[k] = dw; waddr[k] = wa; wdata[k] = wd; wstrb[k] = ws;
        while (rp || wp) begin
            #1;
            c++;
            rv = rp && rvalid[k];
            wv = wp && wvalid[k];
            if (rp) check($sformatf("rvalid_lat_u%0d_c%0d", k, c), 32'(rv), 32'(c == int'(rdw(k)) + 1));
            if (wp) check($sformatf("wvalid_lat_u%0d_c%0d", k, c), 32'(wv), 32'(c == int'(wrw(k)) + 1));
            if (rv) begin
                e.k = k;
                if (in_rng(ra)) begin
                    e.data = mrd(k, ra);
                    e.resp = 1'b1;
`ifdef DMEM_RAW_FWD_EN
                    if (wv && in_rng(wa) && ra[15:2] == wa[15:2]) e.data = merge(e.data, wd, ws);
`endif
                end else begin
                    e.data = 32'h0;
                    e.resp = 1'b0;
                    err_exp[k] = 1'b1;
                end
                sbq.push_back(e);
            end
            if (wv) begin
                if (in_rng(wa)) mdl[key(k, wa)] = merge(mrd(k, wa), wd, ws);
                else            err_exp[k] = 1'b1;
            end
            @(negedge clk);
            if (rv) begin rready[k] = 1'b0; rp = 1'b0; end
            if (wv) begin wready[k] = 1'b0; wp = 1'b0; end
            if (c >= 12 && (rp || wp)) begin
                n_chk++;
                n_fail++;
                $display("FAIL xfer_timeout_u%0d: no handshake after %0d cycles, required %0d/%0d",
                         k, c, rdw(k) + 1, wrw(k) + 1);
                rready[k] = 1'b0; wready[k] = 1'b0;
                rp = 1'b0; wp = 1'b0;
            end
        end
    endtask

    task automatic rd(input int k, input logic [31:0] a);
        xfer(k, 1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        xfer(k, 1'b0, 32'h0, 1'b1, a, d, s);
    endtask

    // Two reset cycles. In the first, instance 0 requests on both channels,
    // which must be ignored.
    task automatic do_reset();
        resetb = 1'b0;
        for (int k = 0; k < NI; k++) begin rready[k] = 1'b0; wready[k] = 1'b0; end
        rready[0] = 1'b1; raddr[0] = 32'h2000_0010;
        wready[0] = 1'b1; waddr[0] = 32'h2000_0010; wdata[0] = 32'hBAD0_BAD0; wstrb[0] = 4'hF;
        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_rvalid_u%0d", k), 32'(rvalid[k]), 32'h0);
            check($sformatf("rst_wvalid_u%0d", k), 32'(wvalid[k]), 32'h0);
            check($sformatf("rst_rdata_u%0d", k),  rdata[k],       32'h0);
            check($sformatf("rst_rresp_u%0d", k),  32'(rresp[k]),  32'h0);
            check($sformatf("rst_err_u%0d", k),    32'(err[k]),    32'h0);
        end
        @(negedge clk);
        rready[0] = 1'b0; wready[0] = 1'b0;
        resetb = 1'b1;
        for (int k = 0; k < NI; k++) err_exp[k] = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'h2000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a[31:28] = 4'h5;
        return a;
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin
        bit      hr [NI];
        bit      ha [NI];
        rd_exp_t e;
        for (int k = 0; k < NI; k++) begin hr[k] = 1'b0; ha[k] = 1'b0; end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (hr[k]) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_underflow_u%0d: read handshake with no expected entry", k);
                    end else begin
                        e = sbq.pop_front();
                        check($sformatf("sb_unit_u%0d", k), 32'(k), 32'(e.k));
                        check($sformatf("rdata_u%0d", k), rdata[k], e.data);
                        check($sformatf("rresp_u%0d", k), 32'(rresp[k]), 32'(e.resp));
                    end
                end
                if (ha[k]) check($sformatf("err_u%0d", k), 32'(err[k]), 32'(err_exp[k]));
            end
            #2;
            for (int k = 0; k < NI; k++) begin
                hr[k] = resetb && rready[k] && rvalid[k];
                ha[k] = hr[k] || (resetb && wready[k] && wvalid[k]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        resetb = 1'b0;
        for (int k = 0; k < NI; k++) begin
            rready[k] = 1'b0; wready[k] = 1'b0;
            raddr[k]  = '0;   waddr[k]  = '0; wdata[k] = '0; wstrb[k] = '0;
            err_exp[k] = 1'b0;
        end
        @(negedge clk);
        do_reset();

        // Zero wait states: write, then read back-to-back.
        wr(0, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF);
        rd(0, 32'h2000_0010);
        // Byte strobes, then an empty strobe.
        wr(0, 32'h2000_0010, 32'h0000_5500, 4'b0010);
        rd(0, 32'h2000_0010);
        wr(0, 32'h2000_0010, 32'hFFFF_FFFF, 4'b0000);
        rd(0, 32'h2000_0010);
        // Out-of-range read and write; the aliasing in-range word stays intact.
        wr(0, 32'h2000_0004, 32'h1234_5678, 4'hF);
        rd(0, 32'h3000_0000);
        wr(0, 32'h1000_0004, 32'hFFFF_FFFF, 4'hF);
        rd(0, 32'h2000_0004);
        // Same-cycle read and write to one word.
        wr(0, 32'h2000_0020, 32'h1122_3344, 4'hF);
        xfer(0, 1'b1, 32'h2000_0020, 1'b1, 32'h2000_0020, 32'hAABB_CCDD, 4'b0101);
        rd(0, 32'h2000_0020);
        // Reset clears err. A request presented during reset is discarded.
        do_reset();
        rd(0, 32'h2000_0010);

        // Wait states (2 read / 3 write) and an abandoned read.
        wr(1, 32'h2000_0040, 32'h0BAD_F00D, 4'hF);
        rd(1, 32'h2000_0040);
        rready[1] = 1'b1; raddr[1] = 32'h2000_0040;
        #1 check("abandon_rvalid_u1", 32'(rvalid[1]), 32'h0);
        @(negedge clk);
        rready[1] = 1'b0;
        @(negedge clk);
        rd(1, 32'h2000_0040);

        // Reset in the middle of a 3-cycle read wait.
        wr(2, 32'h2000_0080, 32'hCAFE_F00D, 4'hF);
        rd(2, 32'h2000_0080);
        rready[2] = 1'b1; raddr[2] = 32'h2000_0080;
        @(negedge clk);
        @(negedge clk);
        #1 check("midwait_rvalid_u2", 32'(rvalid[2]), 32'h0);
        resetb = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_rvalid_u2", 32'(rvalid[2]), 32'h0);
        check("midrst_rresp_u2",  32'(rresp[2]),  32'h0);
        check("midrst_rdata_u2",  rdata[2],       32'h0);
        @(negedge clk);
        rready[2] = 1'b0;
        resetb = 1'b1;
        for (int k = 0; k < NI; k++) err_exp[k] = 1'b0;
        rd(2, 32'h2000_0080);

        // Randomised traffic on every instance.
        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 16; w++) wr(k, 32'h2000_0000 + 32'(w * 4), $urandom, 4'hF);
            repeat (50) begin
                int op;
                op = $urandom_range(0, 2);
                xfer(k, op != 1, rnd_addr(), op != 0, rnd_addr(), $urandom, 4'($urandom));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
